// File: rtl/rtc_time_poll_if.sv
// Register-level I2C read port between the RTC poller (master) and the I2C engine (slave).
// One request at a time: rd_req pulses, reg_addr holds until done; data/ack_err qualified by done.
interface rtc_time_poll_if;
   logic       i2c_rd_req;
   logic [6:0] i2c_dev_addr;
   logic [7:0] i2c_reg_addr;
   logic [7:0] i2c_rd_data;
   logic       i2c_done;
   logic       i2c_ack_err;

   modport master (
      output i2c_rd_req,
      output i2c_dev_addr,
      output i2c_reg_addr,
      input  i2c_rd_data,
      input  i2c_done,
      input  i2c_ack_err
   );

   modport slave (
      input  i2c_rd_req,
      input  i2c_dev_addr,
      input  i2c_reg_addr,
      output i2c_rd_data,
      output i2c_done,
      output i2c_ack_err
   );
endinterface

// File: rtl/rtc_time_poll.sv
// Polls RTC regs 0x00-0x06 every POLL_CYC clocks, publishes BCD time/date 2 cycles after the last read
// when seconds changed; one outstanding I2C read at a time, ticks arriving mid-sequence are dropped.
module rtc_time_poll #(
   parameter int unsigned POLL_CYC    = 5_000_000,
   parameter int unsigned TIMEOUT_CYC = 50_000,
   parameter logic [6:0]  DEV_ADDR    = 7'h68
) (
   input  logic                  clk,
   input  logic                  rstn,
   rtc_time_poll_if.master       i2c,
   output logic [23:0]           time_data,
   output logic [31:0]           date_data,
   output logic                  date_time_en,
   output logic                  rtc_err
);

   localparam int unsigned PCW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
   localparam int unsigned TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_CHECK,
      S_ERR
   } state_t;

   state_t         state_q, state_d;
   logic [PCW-1:0] pcnt_q, pcnt_d;
   logic [TCW-1:0] tcnt_q, tcnt_d;
   logic [2:0]     idx_q, idx_d;
   logic           first_q, first_d;
   logic           rd_req_q, rd_req_d;
   logic [7:0]     shadow_q [0:6];
   logic [7:0]     shadow_d [0:6];
   logic [23:0]    time_q, time_d;
   logic [31:0]    date_q, date_d;
   logic           en_q, en_d;
   logic           err_q, err_d;
   logic           tick;

   // Strip control/flag bits so only BCD digits reach the outputs (24 h mode, century dropped).
   function automatic logic [7:0] reg_mask(input logic [2:0] r);
      logic [7:0] m;
      case (r)
         3'd0:    m = 8'h7F;
         3'd1:    m = 8'h7F;
         3'd2:    m = 8'h3F;
         3'd3:    m = 8'h07;
         3'd4:    m = 8'h3F;
         3'd5:    m = 8'h1F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   assign tick = (pcnt_q == PCW'(POLL_CYC - 1));

   always_comb begin
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      idx_d    = idx_q;
      first_d  = first_q;
      shadow_d = shadow_q;
      time_d   = time_q;
      date_d   = date_q;
      rd_req_d = 1'b0;
      en_d     = 1'b0;
      err_d    = 1'b0;
      pcnt_d   = tick ? '0 : pcnt_q + PCW'(1);

      case (state_q)
         S_IDLE: begin
            if (tick) begin
               idx_d    = 3'd0;
               rd_req_d = 1'b1;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            tcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A done in the same cycle as the timeout limit still counts as an answer.
            if (i2c.i2c_done) begin
               if (i2c.i2c_ack_err) begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else begin
                  shadow_d[idx_q] = i2c.i2c_rd_data & reg_mask(idx_q);
                  if (idx_q != 3'd6) begin
                     idx_d    = idx_q + 3'd1;
                     rd_req_d = 1'b1;
                     state_d  = S_REQ;
                  end else begin
                     state_d = S_CHECK;
                  end
               end
            end else if (tcnt_q == TCW'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               tcnt_d = tcnt_q + TCW'(1);
            end
         end
         S_CHECK: begin
            if (first_q || (shadow_q[0] != time_q[7:0])) begin
               time_d  = {shadow_q[2], shadow_q[1], shadow_q[0]};
               date_d  = {shadow_q[6], shadow_q[5], shadow_q[4], shadow_q[3]};
               en_d    = 1'b1;
               first_d = 1'b0;
            end
            state_d = S_IDLE;
         end
         S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         pcnt_q   <= '0;
         tcnt_q   <= '0;
         idx_q    <= 3'd0;
         first_q  <= 1'b1;
         rd_req_q <= 1'b0;
         shadow_q <= '{default: 8'h00};
         time_q   <= '0;
         date_q   <= '0;
         en_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pcnt_q   <= pcnt_d;
         tcnt_q   <= tcnt_d;
         idx_q    <= idx_d;
         first_q  <= first_d;
         rd_req_q <= rd_req_d;
         shadow_q <= shadow_d;
         time_q   <= time_d;
         date_q   <= date_d;
         en_q     <= en_d;
         err_q    <= err_d;
      end
   end

   assign i2c.i2c_rd_req   = rd_req_q;
   assign i2c.i2c_dev_addr = DEV_ADDR;
   assign i2c.i2c_reg_addr = {5'd0, idx_q};
   assign time_data        = time_q;
   assign date_data        = date_q;
   assign date_time_en     = en_q;
   assign rtc_err          = err_q;

endmodule

// File: tb/tb_rtc_time_poll.sv
// Bench for rtc_time_poll: I2C slave model, event-scheduled reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_rtc_time_poll;
   localparam int POLL = 200;
   localparam int TMO  = 50;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [23:0] time_data;
   logic [31:0] date_data;
   logic        date_time_en;
   logic        rtc_err;

   always #5 clk = ~clk;

   rtc_time_poll_if i2c ();

   rtc_time_poll #(.POLL_CYC(POLL), .TIMEOUT_CYC(TMO), .DEV_ADDR(7'h68)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .i2c          (i2c),
      .time_data    (time_data),
      .date_data    (date_data),
      .date_time_en (date_time_en),
      .rtc_err      (rtc_err)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endfunction

   // ---------------- I2C slave model ----------------
   logic [7:0] rtc_bytes [7];
   int  lat       = 20;
   int  nack_reg  = -1;
   int  drop_reg  = -1;
   bit  rand_mode = 1'b0;
   int  gcyc      = 0;
   int  n_req     = 0;
   int  last_req_cyc [7];
   int  last_req_addr = -1;
   int  prev_a0_cyc = -1;
   int  last_a0_cyc = -1;
   int  last_done_cyc = -1;
   int  addr_log [$];
   bit  pend = 1'b0;
   int  cd, cur_addr, l;
   bit  cur_nack;
   logic [7:0] b;

   initial begin
      i2c.i2c_done    = 1'b0;
      i2c.i2c_ack_err = 1'b0;
      i2c.i2c_rd_data = 8'h00;
      forever begin
         @(posedge clk);
         gcyc++;
         #1;
         i2c.i2c_done    = 1'b0;
         i2c.i2c_ack_err = 1'b0;
         if (!rstn) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               if (cd == 0) begin
                  pend = 1'b0;
                  if (rand_mode) begin
                     b = 8'($urandom);
                     if (cur_addr == 0) b = (b & 8'h80) | 8'($urandom_range(0, 2));
                  end else begin
                     b = rtc_bytes[cur_addr];
                  end
                  i2c.i2c_rd_data = b;
                  i2c.i2c_done    = 1'b1;
                  i2c.i2c_ack_err = cur_nack;
                  last_done_cyc   = gcyc;
               end else begin
                  cd--;
               end
            end
            if (i2c.i2c_rd_req) begin
               chk("req_no_overlap", 64'(pend), 64'(0));
               chk("dev_addr", 64'(i2c.i2c_dev_addr), 64'(7'h68));
               cur_addr = int'(i2c.i2c_reg_addr);
               if (cur_addr > 6) cur_addr = 6;
               n_req++;
               addr_log.push_back(cur_addr);
               last_req_cyc[cur_addr] = gcyc;
               last_req_addr = cur_addr;
               if (cur_addr == 0) begin
                  prev_a0_cyc = last_a0_cyc;
                  last_a0_cyc = gcyc;
               end
               if (rand_mode) begin
                  l        = $urandom_range(1, TMO);
                  cur_nack = ($urandom_range(0, 24) == 0);
               end else begin
                  l        = (cur_addr == drop_reg) ? TMO + 10 : lat;
                  cur_nack = (cur_addr == nack_reg);
               end
               pend = 1'b1;
               cd   = l - 1;
            end
         end
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   // Cycle c = clocks since reset release; everything is scheduled as absolute cycle numbers.
   logic [7:0]  mask [7] = '{8'h7F, 8'h7F, 8'h3F, 8'h07, 8'h3F, 8'h1F, 8'hFF};
   logic [7:0]  sh [7];
   logic [23:0] pub_t, nxt_t;
   logic [31:0] pub_d, nxt_d;
   int  c, busy_end, req_cyc, cur_reg, en_cyc, err_cyc;
   bit  waiting, first;
   int  n_en = 0, n_err = 0, last_en_cyc = -1, last_err_cyc = -1;

   task automatic model_reset();
      c = 0; busy_end = -1; req_cyc = -1; cur_reg = 0;
      en_cyc = -1; err_cyc = -1; waiting = 1'b0; first = 1'b1;
      pub_t = '0; pub_d = '0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rstn) begin
            model_reset();
            chk("rst_rd_req", 64'(i2c.i2c_rd_req), 64'(0));
            chk("rst_en", 64'(date_time_en), 64'(0));
            chk("rst_err", 64'(rtc_err), 64'(0));
            chk("rst_time", 64'(time_data), 64'(0));
            chk("rst_date", 64'(date_data), 64'(0));
         end else begin
            if (c == en_cyc) begin
               pub_t = nxt_t;
               pub_d = nxt_d;
            end
            chk("rd_req", 64'(i2c.i2c_rd_req), 64'(c == req_cyc));
            chk("reg_addr", 64'(i2c.i2c_reg_addr), 64'(cur_reg));
            chk("date_time_en", 64'(date_time_en), 64'(c == en_cyc));
            chk("rtc_err", 64'(rtc_err), 64'(c == err_cyc));
            chk("time_data", 64'(time_data), 64'(pub_t));
            chk("date_data", 64'(date_data), 64'(pub_d));
            if (date_time_en) begin n_en++;  last_en_cyc  = gcyc; end
            if (rtc_err)      begin n_err++; last_err_cyc = gcyc; end

            if (waiting && c > req_cyc) begin
               if (i2c.i2c_done) begin
                  if (i2c.i2c_ack_err) begin
                     waiting = 1'b0; err_cyc = c + 1; busy_end = c + 1;
                  end else begin
                     sh[cur_reg] = i2c.i2c_rd_data & mask[cur_reg];
                     if (cur_reg < 6) begin
                        cur_reg++;
                        req_cyc = c + 1;
                     end else begin
                        waiting = 1'b0; busy_end = c + 1;
                        if (first || sh[0] != pub_t[7:0]) begin
                           first  = 1'b0;
                           nxt_t  = {sh[2], sh[1], sh[0]};
                           nxt_d  = {sh[6], sh[5], sh[4], sh[3]};
                           en_cyc = c + 2;
                        end
                     end
                  end
               end else if (c == req_cyc + TMO) begin
                  waiting = 1'b0; err_cyc = c + 1; busy_end = c + 1;
               end
            end
            if ((c % POLL) == POLL - 1 && c > busy_end) begin
               cur_reg  = 0;
               req_cyc  = c + 1;
               waiting  = 1'b1;
               busy_end = 1 << 30;
            end
            c++;
         end
      end
   end

   // ---------------- bounded waits ----------------
   task automatic wait_en(input int bound, input string nm);
      int base = n_en;
      int k = 0;
      while (n_en == base && k < bound) begin @(posedge clk); k++; end
      #2;
      chk(nm, 64'(n_en != base), 64'(1));
   endtask

   task automatic wait_err(input int bound, input string nm);
      int base = n_err;
      int k = 0;
      while (n_err == base && k < bound) begin @(posedge clk); k++; end
      #2;
      chk(nm, 64'(n_err != base), 64'(1));
   endtask

   task automatic wait_reqs(input int n, input int bound, input string nm);
      int base = n_req;
      int k = 0;
      while (n_req - base < n && k < bound) begin @(posedge clk); k++; end
      #2;
      chk(nm, 64'(n_req - base >= n), 64'(1));
   endtask

   task automatic wait_req_addr(input int a, input int bound, input string nm);
      int base = n_req;
      int k = 0;
      while (!(n_req > base && last_req_addr == a) && k < bound) begin @(posedge clk); k++; end
      #2;
      chk(nm, 64'(last_req_addr), 64'(a));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios + random soak ----------------
   int base_en, base_req, rel_cyc;

   initial begin
      rtc_bytes = '{8'h85, 8'h59, 8'h23, 8'h03, 8'h31, 8'h92, 8'h24};
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_time", 64'(time_data), 64'(24'h000000));
      chk("reset_date", 64'(date_data), 64'(32'h00000000));
      chk("reset_req", 64'(i2c.i2c_rd_req), 64'(0));
      chk("reset_reg_addr", 64'(i2c.i2c_reg_addr), 64'(0));
      chk("reset_dev_addr", 64'(i2c.i2c_dev_addr), 64'(7'h68));
      @(posedge clk);
      #2 rstn = 1'b1;

      // First read after reset always publishes; masked fields.
      wait_en(POLL + 7 * 21 + 20, "first_read_en");
      chk("first_time", 64'(time_data), 64'(24'h235905));
      chk("first_date", 64'(date_data), 64'(32'h24123103));
      chk("en_after_last_done", 64'(last_en_cyc - last_done_cyc), 64'(2));
      chk("req_log_size", 64'(addr_log.size()), 64'(7));
      for (int i = 0; i < 7 && i < addr_log.size(); i++)
         chk("req_order", 64'(addr_log[i]), 64'(i));

      // Same seconds: full read, no pulse.
      base_en = n_en; base_req = n_req;
      wait_reqs(7, 2 * POLL + 200, "same_sec_reads");
      repeat (40) @(posedge clk);
      #2;
      chk("same_sec_req_count", 64'(n_req - base_req), 64'(7));
      chk("same_sec_no_en", 64'(n_en - base_en), 64'(0));
      chk("same_sec_time", 64'(time_data), 64'(24'h235905));
      rtc_bytes[0] = 8'h06;
      wait_en(2 * POLL + 200, "new_sec_en");
      chk("new_sec_time", 64'(time_data), 64'(24'h235906));

      // NACK on register 3.
      nack_reg = 3; base_req = n_req; base_en = n_en;
      wait_err(2 * POLL + 200, "nack_err");
      nack_reg = -1;
      repeat (10) @(posedge clk);
      #2;
      chk("nack_req_count", 64'(n_req - base_req), 64'(4));
      chk("nack_last_addr", 64'(last_req_addr), 64'(3));
      chk("nack_no_en", 64'(n_en - base_en), 64'(0));
      chk("nack_time_held", 64'(time_data), 64'(24'h235906));
      rtc_bytes[0] = 8'h07;
      wait_en(2 * POLL + 200, "after_nack_en");
      chk("after_nack_time", 64'(time_data), 64'(24'h235907));

      // Register 2 never answered in time; late done lands in IDLE.
      drop_reg = 2;
      wait_err(2 * POLL + 200, "timeout_err");
      drop_reg = -1;
      chk("timeout_latency", 64'(last_err_cyc - last_req_cyc[2]), 64'(51));
      chk("timeout_date_held", 64'(date_data), 64'(32'h24123103));
      rtc_bytes[0] = 8'h08;
      wait_en(2 * POLL + 200, "after_timeout_en");
      chk("after_timeout_time", 64'(time_data), 64'(24'h235908));

      // Reset while waiting on register 4; same seconds must still publish afterwards.
      wait_req_addr(4, 2 * POLL + 200, "reach_reg4");
      repeat (5) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("midrst_time", 64'(time_data), 64'(0));
      chk("midrst_date", 64'(date_data), 64'(0));
      chk("midrst_req", 64'(i2c.i2c_rd_req), 64'(0));
      chk("midrst_addr", 64'(i2c.i2c_reg_addr), 64'(0));
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      rel_cyc = gcyc;
      wait_en(POLL + 7 * 21 + 40, "post_reset_en");
      chk("post_reset_first_req", 64'(last_a0_cyc - rel_cyc), 64'(POLL));
      chk("post_reset_time", 64'(time_data), 64'(24'h235908));
      chk("post_reset_date", 64'(date_data), 64'(32'h24123103));

      // Slow master: sequence outlasts the poll period, middle tick is dropped.
      lat = 40;
      rtc_bytes[0] = 8'h09;
      wait_reqs(8, 4 * POLL + 400, "slow_two_starts");
      chk("slow_start_gap", 64'(last_a0_cyc - prev_a0_cyc), 64'(2 * POLL));
      repeat (320) @(posedge clk);
      lat = 20;

      // Random soak: random bytes, latencies up to the timeout limit, occasional NACK.
      base_en = n_en;
      rand_mode = 1'b1;
      repeat (4000) @(posedge clk);
      rand_mode = 1'b0;
      repeat (TMO + 5) @(posedge clk);
      #2;
      chk("random_pulses_seen", 64'(n_en > base_en), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
